// File: rtl/coriolis_addsub_pipe.sv
// ---------------------------------------------------------------------------
// coriolis_addsub_pipe
//
// Elastic add/subtract map node for generated kernel pipelines. An operand
// pair is consumed only when both operand streams are valid and the node is
// ready. Stage 1 computes the sum or difference, the overflow flag and the
// optional saturation. Stages 2..LAT only delay the result. Empty stages are
// filled even while the output is stalled, so the node only pushes back on
// upstream once every stage holds data.
//
// Parameters
//   STREAMW : operand/result width (8..64)
//   LAT     : stages from input accept to output (1..4)
//   SIGNED  : 1 = two's-complement, 0 = unsigned
//   SAT     : 1 = clamp on overflow, 0 = wrap modulo 2^STREAMW
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous, active-low reset
//   ivalid_in1 : operand 1 valid
//   ivalid_in2 : operand 2 valid
//   in1, in2   : operands
//   op_in      : 0 = in1+in2, 1 = in1-in2, sampled with the operands
//   iready     : node accepts an operand pair this cycle
//   ovalid     : out1/ovf hold a valid result
//   out1       : result
//   ovf        : overflow/underflow occurred for this result
//   oready     : downstream takes the result this cycle
// ---------------------------------------------------------------------------
module coriolis_addsub_pipe #(
  parameter int STREAMW = 32,
  parameter int LAT     = 2,
  parameter int SIGNED  = 0,
  parameter int SAT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in1,
  input  logic [STREAMW-1:0] in2,
  input  logic               op_in,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  output logic               ovf,
  input  logic               oready
);

  localparam int W = STREAMW;

  // Per-stage state; index 1 is the compute stage, index LAT drives the output.
  logic [LAT:1] v_reg;
  logic [LAT:1] ovf_reg;
  logic [W-1:0] res_reg [1:LAT];

  logic [LAT:1] adv;
  logic         acc;

  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic [W:0]   sum_ext;
  logic [W-1:0] res_next;
  logic         ovf_next;

  // A stage may advance when it is empty or when every stage downstream of
  // it can move. Written in closed form (some stage from gi to LAT is empty,
  // or the output is taken) so no combinational chain runs through the
  // vector itself.
  generate
    for (genvar gi = 1; gi <= LAT; gi++) begin : g_adv
      assign adv[gi] = oready | ~(&v_reg[LAT:gi]);
    end
  endgenerate

  // Held low during reset so nothing is taken while the node is cleared.
  assign iready = rst & adv[1];
  assign acc    = ivalid_in1 & ivalid_in2 & iready;

  // Stage 1 arithmetic: one extra bit carries the carry/borrow (unsigned)
  // or keeps the true sign of the extended result (signed).
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {in1[W-1], in1};
      b_ext = {in2[W-1], in2};
    end else begin
      a_ext = {1'b0, in1};
      b_ext = {1'b0, in2};
    end

    sum_ext = op_in ? (a_ext - b_ext) : (a_ext + b_ext);

    if (SIGNED != 0) begin
      // Add overflows only when the operand signs agree; subtract only when
      // they differ. In both cases the wrapped result then has the wrong sign
      // relative to in1.
      ovf_next = (op_in ? (in1[W-1] != in2[W-1]) : (in1[W-1] == in2[W-1]))
                 & (sum_ext[W-1] != in1[W-1]);
    end else begin
      ovf_next = sum_ext[W];
    end

    res_next = sum_ext[W-1:0];
    if ((SAT != 0) && ovf_next) begin
      if (SIGNED != 0) begin
        // A signed overflow always moves away from in1's sign, so in1
        // tells which rail to clamp to.
        res_next = in1[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        // Unsigned add can only overflow upward, subtract only downward.
        res_next = op_in ? '0 : '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_reg   <= '0;
      ovf_reg <= '0;
      for (int k = 1; k <= LAT; k++) begin
        res_reg[k] <= '0;
      end
    end else begin
      if (adv[1]) begin
        v_reg[1] <= acc;
        if (acc) begin
          res_reg[1] <= res_next;
          ovf_reg[1] <= ovf_next;
        end
      end
      // Data only moves with a valid token, so an output that is not taken
      // holds its value and bubbles never overwrite anything.
      for (int k = 2; k <= LAT; k++) begin
        if (adv[k]) begin
          v_reg[k] <= v_reg[k-1];
          if (v_reg[k-1]) begin
            res_reg[k] <= res_reg[k-1];
            ovf_reg[k] <= ovf_reg[k-1];
          end
        end
      end
    end
  end

  assign ovalid = v_reg[LAT];
  assign out1   = res_reg[LAT];
  assign ovf    = ovf_reg[LAT];

endmodule
